// File: rtl/sm_dbus_arbiter_pkg.sv
// Shared definitions for the two-master data-bus arbiter.
package sm_dbus_arbiter_pkg;

  typedef enum logic [1:0] {
    SM_ARB_IDLE   = 2'd0,
    SM_ARB_ACCESS = 2'd1,
    SM_ARB_DONE   = 2'd2
  } arb_state_e;

  localparam logic SM_ARB_M_CPU = 1'b0;
  localparam logic SM_ARB_M_DBG = 1'b1;

  // Removes the current owner from the request vector so that the
  // owner's still-high request cannot win again in its own ack cycle.
  function automatic logic [1:0] mask_owner(input logic [1:0] req, input logic owner);
    mask_owner = (owner == SM_ARB_M_DBG) ? (req & 2'b01) : (req & 2'b10);
  endfunction

endpackage

// File: rtl/sm_dbus_arbiter_pick.sv
// Combinational two-way picker: one request wins outright; on a tie the
// master not granted last wins in round-robin mode, else master 0 wins.
module sm_arb_pick
  import sm_dbus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr,
  output logic       grant,
  output logic       valid
);

  // Winner selection
  always_comb begin
    valid = |req;
    grant = SM_ARB_M_CPU;
    if (req == 2'b10) begin
      grant = SM_ARB_M_DBG;
    end else if (req == 2'b11 && rr) begin
      grant = ~last;
    end
  end

endmodule

// File: rtl/sm_dbus_arbiter.sv
// Two-master arbiter for the bus-matrix data port. Each access runs
// IDLE/DONE -> ACCESS -> DONE; acks and read data come back in DONE.
//
//   state  | meaning
//   IDLE   | no transaction in flight
//   ACCESS | bus driven by owner; read data captured at the closing edge
//   DONE   | owner's ack high, mRData valid; other master may be granted
module sm_dbus_arbiter
  import sm_dbus_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit RR         = 1'b1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0Req,
  input  logic                  m1Req,
  input  logic [DATA_WIDTH-1:0] m0Addr,
  input  logic [DATA_WIDTH-1:0] m1Addr,
  input  logic                  m0Write,
  input  logic                  m1Write,
  input  logic [DATA_WIDTH-1:0] m0WData,
  input  logic [DATA_WIDTH-1:0] m1WData,
  output logic                  m0Ack,
  output logic                  m1Ack,
  output logic [DATA_WIDTH-1:0] mRData,
  output logic [DATA_WIDTH-1:0] bAddr,
  output logic                  bWrite,
  output logic [DATA_WIDTH-1:0] bWData,
  input  logic [DATA_WIDTH-1:0] bRData,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  grantCnt0,
  output logic [CNT_WIDTH-1:0]  grantCnt1
);

  arb_state_e            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CNT_WIDTH-1:0]  cnt0_q, cnt1_q;

  logic [1:0] req_raw, pick_req;
  logic       pick_grant, pick_valid;
  logic       in_access;

  assign req_raw   = {m1Req, m0Req};
  assign in_access = (state_q == SM_ARB_ACCESS);

  // One picker serves both decisions; in DONE the owner is masked out
  always_comb begin
    pick_req = req_raw;
    if (state_q == SM_ARB_DONE) pick_req = mask_owner(req_raw, owner_q);
  end

  sm_arb_pick u_pick (
    .req   (pick_req),
    .last  (last_q),
    .rr    (RR),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // Next-state and ownership decision
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      SM_ARB_IDLE, SM_ARB_DONE: begin
        state_d = SM_ARB_IDLE;
        if (pick_valid) begin
          state_d = SM_ARB_ACCESS;
          owner_d = pick_grant;
          last_d  = pick_grant;
        end
      end
      SM_ARB_ACCESS: state_d = SM_ARB_DONE;
      default:       state_d = SM_ARB_IDLE;
    endcase
  end

  // Bus mux: the matrix sees all-zero outputs outside ACCESS
  always_comb begin
    bAddr  = '0;
    bWData = '0;
    bWrite = 1'b0;
    if (in_access) begin
      bAddr  = (owner_q == SM_ARB_M_DBG) ? m1Addr  : m0Addr;
      bWData = (owner_q == SM_ARB_M_DBG) ? m1WData : m0WData;
      bWrite = (owner_q == SM_ARB_M_DBG) ? m1Write : m0Write;
    end
  end

  // State, read-data capture and saturating grant counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SM_ARB_IDLE;
      owner_q <= SM_ARB_M_CPU;
      last_q  <= SM_ARB_M_DBG;
      rdata_q <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      if (in_access && !bWrite) rdata_q <= bRData;
      if (state_q == SM_ARB_DONE) begin
        if (owner_q == SM_ARB_M_CPU && cnt0_q != {CNT_WIDTH{1'b1}})
          cnt0_q <= cnt0_q + CNT_WIDTH'(1);
        if (owner_q == SM_ARB_M_DBG && cnt1_q != {CNT_WIDTH{1'b1}})
          cnt1_q <= cnt1_q + CNT_WIDTH'(1);
      end
    end
  end

  assign m0Ack     = (state_q == SM_ARB_DONE) && (owner_q == SM_ARB_M_CPU);
  assign m1Ack     = (state_q == SM_ARB_DONE) && (owner_q == SM_ARB_M_DBG);
  assign busy      = (state_q != SM_ARB_IDLE);
  assign mRData    = rdata_q;
  assign grantCnt0 = cnt0_q;
  assign grantCnt1 = cnt1_q;

endmodule

// File: tb/tb_sm_dbus_arbiter.sv
// Bench: a round-robin and a fixed-priority instance, each with its own
// masters, compared every cycle against a transaction-level reference.
module tb_sm_dbus_arbiter;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          m_req   [2][2];
  logic          m_wr    [2][2];
  logic [DW-1:0] m_addr  [2][2];
  logic [DW-1:0] m_wdata [2][2];

  logic          ack0 [2], ack1 [2], bwr [2], busy [2];
  logic [DW-1:0] baddr [2], bwd [2], brd [2], mrd [2];
  logic [CW-1:0] gc0 [2], gc1 [2];

  logic          ovr_en;
  logic [DW-1:0] ovr_val;

  function automatic logic [DW-1:0] mem_f(input logic [DW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign brd[0] = ovr_en ? ovr_val : mem_f(baddr[0]);
  assign brd[1] = ovr_en ? ovr_val : mem_f(baddr[1]);

  sm_dbus_arbiter #(.DATA_WIDTH(DW), .RR(1'b1), .CNT_WIDTH(CW)) u_rr (
    .clk(clk), .rst(rst),
    .m0Req(m_req[0][0]), .m1Req(m_req[0][1]),
    .m0Addr(m_addr[0][0]), .m1Addr(m_addr[0][1]),
    .m0Write(m_wr[0][0]), .m1Write(m_wr[0][1]),
    .m0WData(m_wdata[0][0]), .m1WData(m_wdata[0][1]),
    .m0Ack(ack0[0]), .m1Ack(ack1[0]), .mRData(mrd[0]),
    .bAddr(baddr[0]), .bWrite(bwr[0]), .bWData(bwd[0]), .bRData(brd[0]),
    .busy(busy[0]), .grantCnt0(gc0[0]), .grantCnt1(gc1[0])
  );

  sm_dbus_arbiter #(.DATA_WIDTH(DW), .RR(1'b0), .CNT_WIDTH(CW)) u_fp (
    .clk(clk), .rst(rst),
    .m0Req(m_req[1][0]), .m1Req(m_req[1][1]),
    .m0Addr(m_addr[1][0]), .m1Addr(m_addr[1][1]),
    .m0Write(m_wr[1][0]), .m1Write(m_wr[1][1]),
    .m0WData(m_wdata[1][0]), .m1WData(m_wdata[1][1]),
    .m0Ack(ack0[1]), .m1Ack(ack1[1]), .mRData(mrd[1]),
    .bAddr(baddr[1]), .bWrite(bwr[1]), .bWData(bwd[1]), .bRData(brd[1]),
    .busy(busy[1]), .grantCnt0(gc0[1]), .grantCnt1(gc1[1])
  );

  // Reference: which master holds the bus, whether its data phase or ack
  // phase is current, who was granted last, completions and read data.
  int            own [2];
  int            ack_phase [2];
  int            lastg [2];
  int            cnt [2][2];
  logic [DW-1:0] rd [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic string nm(input int i);
    return (i == 0) ? "rr" : "fp";
  endfunction

  task automatic model_step(input int i);
    int w;
    if (rst) begin
      own[i] = -1; ack_phase[i] = 0; lastg[i] = 1;
      cnt[i][0] = 0; cnt[i][1] = 0; rd[i] = '0;
      return;
    end
    if (own[i] >= 0 && ack_phase[i] == 0) begin
      if (!m_wr[i][own[i]]) rd[i] = ovr_en ? ovr_val : mem_f(m_addr[i][own[i]]);
      ack_phase[i] = 1;
    end else if (own[i] >= 0) begin
      if (cnt[i][own[i]] < CMAX) cnt[i][own[i]]++;
      w = 1 - own[i];
      if (m_req[i][w]) begin
        own[i] = w; lastg[i] = w; ack_phase[i] = 0;
      end else begin
        own[i] = -1;
      end
    end else begin
      w = -1;
      if (m_req[i][0] && m_req[i][1]) w = (i == 0) ? 1 - lastg[i] : 0;
      else if (m_req[i][0]) w = 0;
      else if (m_req[i][1]) w = 1;
      if (w >= 0) begin
        own[i] = w; lastg[i] = w; ack_phase[i] = 0;
      end
    end
  endtask

  task automatic check_outputs(input int i);
    logic drv;
    drv = (own[i] >= 0) && (ack_phase[i] == 0);
    check_val({nm(i), " m0Ack"}, ack0[i], own[i] == 0 && ack_phase[i] == 1);
    check_val({nm(i), " m1Ack"}, ack1[i], own[i] == 1 && ack_phase[i] == 1);
    check_val({nm(i), " busy"}, busy[i], own[i] >= 0);
    check_val({nm(i), " bWrite"}, bwr[i], drv ? m_wr[i][own[i]] : 1'b0);
    check_val({nm(i), " bAddr"}, baddr[i], drv ? m_addr[i][own[i]] : '0);
    check_val({nm(i), " bWData"}, bwd[i], drv ? m_wdata[i][own[i]] : '0);
    check_val({nm(i), " mRData"}, mrd[i], rd[i]);
    check_val({nm(i), " cnt0"}, gc0[i], cnt[i][0]);
    check_val({nm(i), " cnt1"}, gc1[i], cnt[i][1]);
  endtask

  task automatic tick();
    for (int i = 0; i < 2; i++) model_step(i);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) check_outputs(i);
  endtask

  task automatic set_req(input int m, input logic r, input logic [DW-1:0] a,
                         input logic w, input logic [DW-1:0] d);
    for (int i = 0; i < 2; i++) begin
      m_req[i][m] = r; m_addr[i][m] = a; m_wr[i][m] = w; m_wdata[i][m] = d;
    end
  endtask

  task automatic new_req(input int i, input int m);
    m_req[i][m]   = 1'b1;
    m_addr[i][m]  = $urandom;
    m_wr[i][m]    = 1'($urandom_range(1, 0));
    m_wdata[i][m] = $urandom;
  endtask

  task automatic masters_random();
    logic a;
    for (int i = 0; i < 2; i++) begin
      for (int m = 0; m < 2; m++) begin
        a = (m == 0) ? ack0[i] : ack1[i];
        if (a) begin
          m_req[i][m] = 1'b0;
          if ($urandom_range(1, 0) == 1) new_req(i, m);
        end else if (m_req[i][m]) begin
          if ($urandom_range(31, 0) == 0) m_req[i][m] = 1'b0;
        end else if ($urandom_range(2, 0) == 0) begin
          new_req(i, m);
        end
      end
    end
  endtask

  int wcount [2];
  int ackat [2];
  int idle_cnt [2];
  int exp_owner;

  initial begin
    rst = 1'b1;
    ovr_en = 1'b0;
    ovr_val = '0;
    for (int i = 0; i < 2; i++) begin
      own[i] = -1; ack_phase[i] = 0; lastg[i] = 1;
      cnt[i][0] = 0; cnt[i][1] = 0; rd[i] = '0;
    end
    set_req(0, 1'b0, '0, 1'b0, '0);
    set_req(1, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      check_val({nm(i), " rst busy"}, busy[i], 1'b0);
      check_val({nm(i), " rst mRData"}, mrd[i], '0);
      check_val({nm(i), " rst cnt"}, {gc1[i], gc0[i]}, '0);
    end
    rst = 1'b0;

    // single read by master 0
    set_req(0, 1'b1, 32'h10, 1'b0, '0);
    ovr_en = 1'b1;
    ovr_val = 32'hDEADBEEF;
    tick();
    for (int i = 0; i < 2; i++) check_val({nm(i), " rd bAddr"}, baddr[i], 32'h10);
    tick();
    for (int i = 0; i < 2; i++) begin
      check_val({nm(i), " rd ack"}, ack0[i], 1'b1);
      check_val({nm(i), " rd data"}, mrd[i], 32'hDEADBEEF);
    end
    set_req(0, 1'b0, 32'h10, 1'b0, '0);
    ovr_en = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) check_val({nm(i), " rd cnt0"}, gc0[i], 1);

    // single write by master 1
    set_req(1, 1'b1, 32'h7F00, 1'b1, 32'h5);
    for (int i = 0; i < 2; i++) begin wcount[i] = 0; ackat[i] = -1; end
    for (int k = 1; k <= 5; k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (bwr[i]) begin
          wcount[i]++;
          check_val({nm(i), " wr data"}, bwd[i], 32'h5);
        end
        if (ack1[i]) ackat[i] = k;
      end
      if (k == 2) set_req(1, 1'b0, 32'h7F00, 1'b1, 32'h5);
    end
    for (int i = 0; i < 2; i++) begin
      check_val({nm(i), " wr strobes"}, wcount[i], 1);
      check_val({nm(i), " wr ack cycle"}, ackat[i], 2);
    end

    // reset during ACCESS of a write
    set_req(1, 1'b1, 32'h20, 1'b1, 32'hAB);
    tick();
    for (int i = 0; i < 2; i++) check_val({nm(i), " acc bWrite"}, bwr[i], 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(1, 1'b0, 32'h20, 1'b1, 32'hAB);
    for (int i = 0; i < 2; i++) begin
      check_val({nm(i), " abort bWrite"}, bwr[i], 1'b0);
      check_val({nm(i), " abort ack"}, ack1[i], 1'b0);
      check_val({nm(i), " abort busy"}, busy[i], 1'b0);
      check_val({nm(i), " abort cnt"}, {gc1[i], gc0[i]}, '0);
    end
    tick();
    for (int i = 0; i < 2; i++) check_val({nm(i), " abort no ack"}, ack1[i], 1'b0);

    // reset during DONE suppresses the count
    set_req(0, 1'b1, 32'h30, 1'b0, '0);
    tick();
    tick();
    for (int i = 0; i < 2; i++) check_val({nm(i), " done ack"}, ack0[i], 1'b1);
    rst = 1'b1;
    set_req(0, 1'b0, 32'h30, 1'b0, '0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_val({nm(i), " done rst ack"}, ack0[i], 1'b0);
      check_val({nm(i), " done rst cnt0"}, gc0[i], 0);
    end

    // both masters requesting continuously
    set_req(0, 1'b1, 32'h100, 1'b0, '0);
    set_req(1, 1'b1, 32'h200, 1'b1, 32'h1);
    for (int i = 0; i < 2; i++) idle_cnt[i] = 0;
    for (int k = 1; k <= 21; k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (k <= 20 && !busy[i]) idle_cnt[i]++;
        if (k % 2 == 0 && k <= 20) begin
          exp_owner = ((k / 2) - 1) % 2;
          check_val({nm(i), " order m0"}, ack0[i], exp_owner == 0);
          check_val({nm(i), " order m1"}, ack1[i], exp_owner == 1);
        end
        for (int m = 0; m < 2; m++)
          if ((m == 0) ? ack0[i] : ack1[i]) new_req(i, m);
      end
    end
    for (int i = 0; i < 2; i++) begin
      check_val({nm(i), " ilv idle"}, idle_cnt[i], 0);
      check_val({nm(i), " ilv cnt0"}, gc0[i], 5);
      check_val({nm(i), " ilv cnt1"}, gc1[i], 5);
    end
    set_req(0, 1'b0, '0, 1'b0, '0);
    set_req(1, 1'b0, '0, 1'b0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // randomized traffic with occasional drops and resets
    for (int k = 0; k < 1600; k++) begin
      rst = (k < 1100 && $urandom_range(249, 0) == 0);
      tick();
      rst = 1'b0;
      masters_random();
    end
    for (int i = 0; i < 2; i++) begin
      check_val({nm(i), " sat cnt0"}, gc0[i], CMAX);
      check_val({nm(i), " sat cnt1"}, gc1[i], CMAX);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
